aes128_iter_ctrl: RTL

Iterative AES-128 encryption engine with one round per clock. It reuses a single SubBytes/ShiftRows/MixColumns/AddRoundKey round datapath for all 10 rounds. Round keys are computed on the fly, one per cycle, so no 1408-bit expanded-key store is needed. It sits between a valid/ready block source and a valid/ready ciphertext sink, and is the area-reduced counterpart of the fully unrolled combinational encryptor.

---
 rtl/aes128_iter_ctrl_pkg.sv | 77 +++++++
 rtl/aes128_iter_ctrl_if.sv | 16 +
 rtl/aes128_iter_ctrl_key_step.sv | 24 ++
 rtl/aes128_iter_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/aes128_iter_ctrl_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 engine.
package aes128_pkg;

   localparam int         NR        = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = x;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) inv = gf_mul(inv, sq);
         sq = gf_mul(sq, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Byte i of a state sits at bits [127-8i -: 8]; index = column*4 + row.
   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(c*4+w) -: 8] = s[127-8*(((c+w)%4)*4+w) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

endpackage

// File: rtl/aes128_iter_ctrl_if.sv
// Block-source / ciphertext-sink handshake bundle for the iterative AES-128 engine.
interface aes128_iter_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;
   logic         busy;

   modport master (output in_valid, plaintext, key, out_ready,
                   input  in_ready, out_valid, ciphertext, busy);
   modport slave  (input  in_valid, plaintext, key, out_ready,
                   output in_ready, out_valid, ciphertext, busy);
endinterface

// File: rtl/aes128_iter_ctrl_key_step.sv
// One step of the AES-128 key schedule: previous round key + rcon -> next round key.
module aes128_key_step
   import aes128_pkg::*;
(
   input  logic [127:0] rk,
   input  logic [7:0]   rcon,
   output logic [127:0] rk_next
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot_w, sub_w, temp_w;
   logic [31:0] n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = rk;
   assign rot_w  = {w3[23:0], w3[31:24]};
   assign sub_w  = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
   assign temp_w = sub_w ^ {rcon, 24'h000000};
   assign n0     = w0 ^ temp_w;
   assign n1     = w1 ^ n0;
   assign n2     = w2 ^ n1;
   assign n3     = w3 ^ n2;
   assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round keys derived on the fly.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a plaintext/key pair, in_ready = 1
// ST_ROUND | applying rounds 1..10, one per cycle
// ST_DONE  | ciphertext valid and held until the sink takes it
module aes128_iter_ctrl
   import aes128_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic               clk,
   input  logic               rst,
   aes128_iter_ctrl_if.slave  bus
);

   if (NR != aes128_pkg::NR) begin : g_bad_nr
      $error("aes128_iter_ctrl: only NR = 10 (AES-128) is supported");
   end

   localparam logic [3:0] LAST_RND = 4'(NR);

   fsm_t         fsm, fsm_nx;
   logic [127:0] state_r, state_nx;
   logic [127:0] rk_r, rk_nx, rk_next;
   logic [7:0]   rcon_r, rcon_nx;
   logic [3:0]   rnd_r, rnd_nx;
   logic [127:0] sr_out, round_out;
   logic         in_ready_c, out_valid_c, busy_c, load;

   aes128_key_step u_key_step (
      .rk      (rk_r),
      .rcon    (rcon_r),
      .rk_next (rk_next)
   );

   // Round datapath; the final round bypasses MixColumns.
   always_comb begin
      sr_out    = shift_rows(sub_bytes(state_r));
      round_out = ((rnd_r == LAST_RND) ? sr_out : mix_columns(sr_out)) ^ rk_next;
   end

   // Next-state and handshake decode; a load in DONE overlaps retirement with the next accept.
   always_comb begin
      fsm_nx      = fsm;
      state_nx    = state_r;
      rk_nx       = rk_r;
      rcon_nx     = rcon_r;
      rnd_nx      = rnd_r;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      busy_c      = 1'b0;
      load        = 1'b0;
      case (fsm)
         ST_IDLE: begin
            in_ready_c = 1'b1;
            load       = bus.in_valid;
         end
         ST_ROUND: begin
            busy_c   = 1'b1;
            state_nx = round_out;
            rk_nx    = rk_next;
            rcon_nx  = xtime(rcon_r);
            if (rnd_r == LAST_RND) fsm_nx = ST_DONE;
            else                   rnd_nx = rnd_r + 4'd1;
         end
         ST_DONE: begin
            busy_c      = 1'b1;
            out_valid_c = 1'b1;
            in_ready_c  = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) load   = 1'b1;
               else              fsm_nx = ST_IDLE;
            end
         end
         default: fsm_nx = ST_IDLE;
      endcase
      if (load) begin
         state_nx = bus.plaintext ^ bus.key;
         rk_nx    = bus.key;
         rcon_nx  = RCON_INIT;
         rnd_nx   = 4'd1;
         fsm_nx   = ST_ROUND;
      end
   end

   // State, key, rcon and round-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm     <= ST_IDLE;
         state_r <= '0;
         rk_r    <= '0;
         rcon_r  <= '0;
         rnd_r   <= '0;
      end else begin
         fsm     <= fsm_nx;
         state_r <= state_nx;
         rk_r    <= rk_nx;
         rcon_r  <= rcon_nx;
         rnd_r   <= rnd_nx;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_c;
   assign bus.busy       = busy_c;
   assign bus.ciphertext = state_r;

endmodule
